// File: rtl/fifo_pkg.sv
// Shared constants and types for the write-side arbitration into the 16x8 FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   FIFO_DEPTH / FIFO_WIDTH : geometry of the shared storage FIFO
//   BEAT_CNT_W / BURST_DEF  : beat counter width and default grant tenure length
//   arb_state_e             : arbiter FSM state, encoded so the bits are the one-hot owner
//   owner_of()              : owner vector decoded from a state
package fifo_pkg;

   localparam int FIFO_DEPTH = 16;
   localparam int FIFO_WIDTH = 8;

   localparam int BEAT_CNT_W = 4;
   localparam int BURST_DEF  = 4;

   // Grant states carry the owner bit pattern directly: bit0 = requester 0,
   // bit1 = requester 1, no bits set = nobody holds the FIFO write port.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } arb_state_e;

   function automatic logic [1:0] owner_of(input arb_state_e s);
      return 2'(s);
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: chooses which requester is granted from idle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is used.
//
// Ports:
//   req0_i, req1_i : pending requests
//   last_i         : last-served requester (0 = requester 0, 1 = requester 1)
//   pick_o         : one-hot choice, 2'b00 when nobody requests
module rr_pick2 (
   input  logic       req0_i,
   input  logic       req1_i,
   input  logic       last_i,
   output logic [1:0] pick_o
);

   always_comb begin
      pick_o = 2'b00;
      if (req0_i && req1_i) begin
         // Tie: favour whoever was not served most recently.
         pick_o = last_i ? 2'b01 : 2'b10;
      end else if (req0_i) begin
         pick_o = 2'b01;
      end else if (req1_i) begin
         pick_o = 2'b10;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Arbitrates two byte writers onto one shared FIFO write port with bounded grant tenures.
// Latency: one cycle from IDLE to grant; once granted, ack/write are combinational (zero cycles).
// Backpressure: fifo_full suppresses ack and write, holding state and beat count until space frees.
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   req0/data0/ack0       : requester 0 handshake (req and data held until ack)
//   req1/data1/ack1       : requester 1 handshake
//   fifo_full             : full flag from the external FIFO
//   fifo_wr_en, fifo_din  : write strobe and byte to the external FIFO
//   owner                 : one-hot current grant (01 req0, 10 req1, 00 none)
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int BURST = BURST_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic [FIFO_WIDTH-1:0] data0,
   output logic                  ack0,
   input  logic                  req1,
   input  logic [FIFO_WIDTH-1:0] data1,
   output logic                  ack1,
   input  logic                  fifo_full,
   output logic                  fifo_wr_en,
   output logic [FIFO_WIDTH-1:0] fifo_din,
   output logic [1:0]            owner
);

   localparam logic [BEAT_CNT_W-1:0] BURST_CNT = BEAT_CNT_W'(BURST);

   arb_state_e            state_q, state_d;
   logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  last_q, last_d;   // 0: requester 0 served last, 1: requester 1

   logic [1:0]            pick;
   logic                  on_one;
   logic                  mine_req;
   logic                  other_req;
   arb_state_e            other_st;
   logic [BEAT_CNT_W-1:0] cnt_inc;

   rr_pick2 u_pick (
      .req0_i (req0),
      .req1_i (req1),
      .last_i (last_q),
      .pick_o (pick)
   );

   // ------------------------------------------------------------------
   // Outputs. Reset is synchronous, so the registered state may still
   // show a grant during the reset cycle; gating here guarantees no write
   // and a clean all-zero interface for as long as reset is high.
   // ------------------------------------------------------------------
   always_comb begin
      ack0     = 1'b0;
      ack1     = 1'b0;
      fifo_din = '0;
      owner    = 2'b00;
      if (!reset) begin
         owner = owner_of(state_q);
         case (state_q)
            ST_GNT0: begin
               ack0     = req0 & ~fifo_full;
               fifo_din = data0;
            end
            ST_GNT1: begin
               ack1     = req1 & ~fifo_full;
               fifo_din = data1;
            end
            default: ;
         endcase
      end
   end

   assign fifo_wr_en = ack0 | ack1;

   // ------------------------------------------------------------------
   // Next state. Both grant states share one description, expressed in
   // terms of "mine" (current owner) and "other".
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      on_one    = (state_q == ST_GNT1);
      mine_req  = on_one ? req1 : req0;
      other_req = on_one ? req0 : req1;
      other_st  = on_one ? ST_GNT0 : ST_GNT1;
      cnt_inc   = cnt_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (pick[0]) begin
               state_d = ST_GNT0;
            end else if (pick[1]) begin
               state_d = ST_GNT1;
            end
         end

         ST_GNT0, ST_GNT1: begin
            if (!mine_req) begin
               // Owner released: hand over immediately or go idle.
               cnt_d   = '0;
               last_d  = on_one;
               state_d = other_req ? other_st : ST_IDLE;
            end else if (fifo_wr_en) begin
               if (cnt_inc == BURST_CNT) begin
                  // Tenure exhausted: yield only if someone else is waiting,
                  // otherwise start a fresh tenure for the same owner.
                  cnt_d = '0;
                  if (other_req) begin
                     state_d = other_st;
                     last_d  = on_one;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            // Owner still requesting but FIFO full: everything holds.
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;   // requester 0 wins the first tie
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

endmodule
